commit_trace_tx: RTL and testbench



---
 rtl/commit_trace_pkg.sv | 23 ++
 rtl/trace_mpush_fifo.sv | 63 ++++++
 rtl/commit_trace_tx.sv | 143 ++++++++++++++
 tb/tb_commit_trace_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types and sizing for the commit-trace transmitter.
// The record layout is fixed by CT_XLEN; the top-level XLEN parameter must match it.
package commit_trace_pkg;

   localparam int CT_NRET  = 2;
   localparam int CT_XLEN  = 64;
   localparam int CT_DEPTH = 8;
   localparam int PTR_W    = $clog2(CT_DEPTH);

   typedef struct packed {
      logic [CT_XLEN-1:0] pc;
      logic [31:0]        insn;
      logic               is_trap;
      logic [CT_XLEN-1:0] code;
   } trace_rec_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } tx_state_e;

endpackage

// File: rtl/trace_mpush_fifo.sv
// Multi-push (up to NPUSH records per cycle), single-pop FIFO of trace records.
// Occupancy comes from a count register so full/empty never rely on pointer compare.
module trace_mpush_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = CT_DEPTH,
   parameter int NPUSH = CT_NRET + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(NPUSH+1)-1:0]   pushCnt,
   input  trace_rec_t                   pushRec [NPUSH],
   input  logic                         pop,
   output trace_rec_t                   headRec,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int PCW = $clog2(NPUSH+1);

   trace_rec_t       memArr [DEPTH];
   logic [PW-1:0]    wrPtrReg;
   logic [PW-1:0]    rdPtrReg;
   logic [CW-1:0]    countReg;
   logic [PW-1:0]    wrAddr [NPUSH];
   logic [NPUSH-1:0] wrEn;

   // Push slot k lands k entries past the write pointer; DEPTH is a power of 2 so this wraps.
   genvar gi;
   generate
      for (gi = 0; gi < NPUSH; gi++) begin : g_slot
         assign wrAddr[gi] = wrPtrReg + PW'(gi);
         assign wrEn[gi]   = (PCW'(gi) < pushCnt);
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int k = 0; k < NPUSH; k++) begin
         if (wrEn[k]) begin
            memArr[wrAddr[k]] <= pushRec[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         wrPtrReg <= wrPtrReg + PW'(pushCnt);
         if (pop) begin
            rdPtrReg <= rdPtrReg + PW'(1);
         end
         countReg <= countReg + CW'(pushCnt) - CW'(pop);
      end
   end

   assign headRec = memArr[rdPtrReg];
   assign count   = countReg;

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: compacts retire/trap events into a FIFO, streams one
// record per cycle on a valid/ready port, and sequences the drain-then-halt shutdown.
module commit_trace_tx
   import commit_trace_pkg::*;
#(
   parameter int NRET  = CT_NRET,
   parameter int XLEN  = CT_XLEN,
   parameter int DEPTH = CT_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NRET-1:0]    ret_valid,
   input  logic [NRET*XLEN-1:0] ret_pc,
   input  logic [NRET*32-1:0] ret_insn,
   input  logic               trap_valid,
   input  logic [XLEN-1:0]    trap_code,
   input  logic               halt_req,
   output logic               ret_ready,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [XLEN-1:0]    trace_pc,
   output logic [31:0]        trace_insn,
   output logic               trace_is_trap,
   output logic [XLEN-1:0]    trace_code,
   output logic               sim_halt,
   output logic [XLEN-1:0]    ret_count,
   output logic               drop_err
);

   localparam int NPUSH = NRET + 1;
   localparam int PCW   = $clog2(NPUSH+1);
   localparam int CW    = $clog2(DEPTH+1);
   // Highest occupancy that still leaves room for a full cycle of events.
   localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - NRET - 1);

   tx_state_e      stateReg;
   tx_state_e      stateNext;
   logic [CW-1:0]  countVal;
   logic           retReady;
   logic           traceValid;
   logic           pop;
   logic           anyEvent;
   logic [PCW-1:0] nRet;
   logic [PCW-1:0] nPush;
   logic [PCW-1:0] pushCnt;
   trace_rec_t     slotRec [NRET];
   trace_rec_t     trapRec;
   trace_rec_t     pushRec [NPUSH];
   trace_rec_t     headRec;
   logic [XLEN-1:0] retCountReg;
   logic           dropErrReg;

   genvar gi;
   generate
      for (gi = 0; gi < NRET; gi++) begin : g_ret
         assign slotRec[gi].pc      = ret_pc[gi*XLEN +: XLEN];
         assign slotRec[gi].insn    = ret_insn[gi*32 +: 32];
         assign slotRec[gi].is_trap = 1'b0;
         assign slotRec[gi].code    = '0;
      end
   endgenerate

   assign trapRec.pc      = '0;
   assign trapRec.insn    = '0;
   assign trapRec.is_trap = 1'b1;
   assign trapRec.code    = trap_code;

   // Pack valid slots oldest-first, then the trap (always youngest) behind them.
   always_comb begin
      for (int k = 0; k < NPUSH; k++) begin
         pushRec[k] = '0;
      end
      nRet = '0;
      for (int i = 0; i < NRET; i++) begin
         if (ret_valid[i]) begin
            pushRec[nRet] = slotRec[i];
            nRet          = nRet + PCW'(1);
         end
      end
      nPush = nRet;
      if (trap_valid) begin
         pushRec[nPush] = trapRec;
         nPush          = nPush + PCW'(1);
      end
   end

   assign retReady   = (stateReg == RUN) && (countVal <= MAX_FILL);
   assign pushCnt    = retReady ? nPush : '0;
   assign traceValid = (countVal != '0) && (stateReg != HALTED);
   assign pop        = traceValid && trace_ready;
   assign anyEvent   = (|ret_valid) || trap_valid;

   trace_mpush_fifo #(
      .DEPTH (DEPTH),
      .NPUSH (NPUSH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .pushCnt (pushCnt),
      .pushRec (pushRec),
      .pop     (pop),
      .headRec (headRec),
      .count   (countVal)
   );

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         RUN:     if (halt_req) stateNext = DRAIN;
         DRAIN:   if (countVal == '0) stateNext = HALTED;
         HALTED:  stateNext = HALTED;
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg    <= RUN;
         retCountReg <= '0;
         dropErrReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         if (retReady) begin
            retCountReg <= retCountReg + XLEN'(nRet);
         end
         if ((stateReg == RUN) && !retReady && anyEvent) begin
            dropErrReg <= 1'b1;
         end
      end
   end

   // Fields read as zero whenever no record is presented, so reset shows all-zero outputs.
   assign trace_valid   = traceValid;
   assign trace_pc      = traceValid ? headRec.pc      : '0;
   assign trace_insn    = traceValid ? headRec.insn    : '0;
   assign trace_is_trap = traceValid ? headRec.is_trap : 1'b0;
   assign trace_code    = traceValid ? headRec.code    : '0;
   assign ret_ready     = retReady;
   assign sim_halt      = (stateReg == HALTED);
   assign ret_count     = retCountReg;
   assign drop_err      = dropErrReg;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed self-checking bench for commit_trace_tx: inputs driven on the falling edge,
// outputs sampled 1 ns later, well away from the rising edge.
module tb_commit_trace_tx;

   localparam int NRET = 2;
   localparam int XLEN = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRET-1:0]   ret_valid;
   logic [NRET*XLEN-1:0] ret_pc;
   logic [NRET*32-1:0] ret_insn;
   logic              trap_valid;
   logic [XLEN-1:0]   trap_code;
   logic              halt_req;
   logic              ret_ready;
   logic              trace_valid;
   logic              trace_ready;
   logic [XLEN-1:0]   trace_pc;
   logic [31:0]       trace_insn;
   logic              trace_is_trap;
   logic [XLEN-1:0]   trace_code;
   logic              sim_halt;
   logic [XLEN-1:0]   ret_count;
   logic              drop_err;

   int nCmp = 0;
   int nBad = 0;

   always #5 clk = ~clk;

   commit_trace_tx #(.NRET(2), .XLEN(64), .DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .ret_valid     (ret_valid),
      .ret_pc        (ret_pc),
      .ret_insn      (ret_insn),
      .trap_valid    (trap_valid),
      .trap_code     (trap_code),
      .halt_req      (halt_req),
      .ret_ready     (ret_ready),
      .trace_valid   (trace_valid),
      .trace_ready   (trace_ready),
      .trace_pc      (trace_pc),
      .trace_insn    (trace_insn),
      .trace_is_trap (trace_is_trap),
      .trace_code    (trace_code),
      .sim_halt      (sim_halt),
      .ret_count     (ret_count),
      .drop_err      (drop_err)
   );

   task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [31:0] i0, input logic [31:0] i1, input logic tv,
                        input logic [63:0] code, input logic hr);
      ret_valid  = v;
      ret_pc     = {pc1, pc0};
      ret_insn   = {i1, i0};
      trap_valid = tv;
      trap_code  = code;
      halt_req   = hr;
   endtask

   task automatic idle();
      drive(2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      trace_ready = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL reset_valid got %b want 0", trace_valid); end
      nCmp++; if (ret_ready !== 1'b1) begin nBad++; $display("FAIL reset_ready got %b want 1", ret_ready); end
      nCmp++; if (sim_halt !== 1'b0) begin nBad++; $display("FAIL reset_halt got %b want 0", sim_halt); end
      nCmp++; if (ret_count !== 64'h0) begin nBad++; $display("FAIL reset_count got %h want 0", ret_count); end
      nCmp++; if (drop_err !== 1'b0) begin nBad++; $display("FAIL reset_drop got %b want 0", drop_err); end
      nCmp++; if (trace_pc !== 64'h0) begin nBad++; $display("FAIL reset_pc got %h want 0", trace_pc); end
      $display("reset: valid=%b ready=%b halt=%b count=%0d", trace_valid, ret_ready, sim_halt, ret_count);
   endtask

   task automatic test_single();
      do_reset();
      trace_ready = 1'b1;
      drive(2'b01, 64'h8000_0000, 64'h0, 32'h0000_0013, 32'h0, 1'b0, 64'h0, 1'b0);
      #1;
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL single_early got %b want 0", trace_valid); end
      @(negedge clk);
      idle();
      #1;
      nCmp++; if (trace_valid !== 1'b1) begin nBad++; $display("FAIL single_valid got %b want 1", trace_valid); end
      nCmp++; if (trace_pc !== 64'h8000_0000) begin nBad++; $display("FAIL single_pc got %h want 80000000", trace_pc); end
      nCmp++; if (trace_insn !== 32'h0000_0013) begin nBad++; $display("FAIL single_insn got %h want 00000013", trace_insn); end
      nCmp++; if (trace_is_trap !== 1'b0) begin nBad++; $display("FAIL single_trap got %b want 0", trace_is_trap); end
      nCmp++; if (ret_count !== 64'd1) begin nBad++; $display("FAIL single_count got %0d want 1", ret_count); end
      $display("single: pc=%h insn=%h trap=%b", trace_pc, trace_insn, trace_is_trap);
      @(negedge clk);
      #1;
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL single_empty got %b want 0", trace_valid); end
   endtask

   task automatic test_sparse_trap();
      do_reset();
      trace_ready = 1'b1;
      drive(2'b10, 64'hDEAD_BEEF, 64'h8000_0004, 32'hFFFF_FFFF, 32'h0000_0513, 1'b1, 64'h2, 1'b0);
      @(negedge clk);
      idle();
      #1;
      nCmp++; if (trace_pc !== 64'h8000_0004) begin nBad++; $display("FAIL sparse_pc got %h want 80000004", trace_pc); end
      nCmp++; if (trace_insn !== 32'h0000_0513) begin nBad++; $display("FAIL sparse_insn got %h want 00000513", trace_insn); end
      nCmp++; if (trace_is_trap !== 1'b0) begin nBad++; $display("FAIL sparse_istrap got %b want 0", trace_is_trap); end
      $display("sparse: pc=%h insn=%h trap=%b", trace_pc, trace_insn, trace_is_trap);
      @(negedge clk);
      #1;
      nCmp++; if (trace_is_trap !== 1'b1) begin nBad++; $display("FAIL trap_flag got %b want 1", trace_is_trap); end
      nCmp++; if (trace_code !== 64'h2) begin nBad++; $display("FAIL trap_code got %h want 2", trace_code); end
      nCmp++; if (trace_pc !== 64'h0) begin nBad++; $display("FAIL trap_pc got %h want 0", trace_pc); end
      $display("sparse: trap code=%h", trace_code);
      @(negedge clk);
      #1;
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL sparse_empty got %b want 0", trace_valid); end
      nCmp++; if (ret_count !== 64'd1) begin nBad++; $display("FAIL sparse_count got %0d want 1", ret_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(2'b11, 64'h100 + 64'(8*c), 64'h104 + 64'(8*c), 32'h100 + 32'(2*c), 32'h101 + 32'(2*c),
               1'b0, 64'h0, 1'b0);
         #1;
         nCmp++; if (ret_ready !== (c < 3)) begin nBad++; $display("FAIL bp_ready c=%0d got %b want %b", c, ret_ready, (c < 3)); end
         if (c >= 1) begin
            nCmp++; if (trace_pc !== 64'h100) begin nBad++; $display("FAIL bp_head c=%0d got %h want 100", c, trace_pc); end
         end
         if (c <= 3) begin
            nCmp++; if (drop_err !== 1'b0) begin nBad++; $display("FAIL bp_drop_early c=%0d got %b want 0", c, drop_err); end
         end
         $display("bp: cycle=%0d ready=%b head=%h", c, ret_ready, trace_pc);
         @(negedge clk);
      end
      idle();
      #1;
      nCmp++; if (drop_err !== 1'b1) begin nBad++; $display("FAIL bp_drop got %b want 1", drop_err); end
      nCmp++; if (trace_insn !== 32'h100) begin nBad++; $display("FAIL bp_hold got %h want 100", trace_insn); end
      trace_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
         nCmp++; if (trace_pc !== 64'h100 + 64'(4*r)) begin nBad++; $display("FAIL bp_order r=%0d got %h want %h", r, trace_pc, 64'h100 + 64'(4*r)); end
         nCmp++; if (trace_insn !== 32'h100 + 32'(r)) begin nBad++; $display("FAIL bp_insn r=%0d got %h want %h", r, trace_insn, 32'h100 + 32'(r)); end
         $display("bp: pop pc=%h insn=%h", trace_pc, trace_insn);
         @(negedge clk);
         #1;
      end
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL bp_empty got %b want 0", trace_valid); end
   endtask

   task automatic test_wrap();
      int k = 0;
      int r = 0;
      do_reset();
      for (int cyc = 0; cyc < 400 && r < 40; cyc++) begin
         trace_ready = (cyc % 2) == 1;
         if (ret_ready && k < 20) begin
            drive(2'b11, 64'h2000 + 64'(8*k), 64'h2004 + 64'(8*k), 32'(2*k), 32'(2*k+1), 1'b0, 64'h0, 1'b0);
            k++;
         end else begin
            idle();
         end
         #1;
         if (trace_valid && trace_ready) begin
            nCmp++; if (trace_pc !== 64'h2000 + 64'(4*r)) begin nBad++; $display("FAIL wrap_pc r=%0d got %h want %h", r, trace_pc, 64'h2000 + 64'(4*r)); end
            nCmp++; if (trace_insn !== 32'(r)) begin nBad++; $display("FAIL wrap_insn r=%0d got %h want %h", r, trace_insn, 32'(r)); end
            $display("wrap: rec %0d pc=%h insn=%h", r, trace_pc, trace_insn);
            r++;
         end
         @(negedge clk);
      end
      idle();
      #1;
      nCmp++; if (r != 40) begin nBad++; $display("FAIL wrap_total got %0d want 40", r); end
      nCmp++; if (ret_count !== 64'd40) begin nBad++; $display("FAIL wrap_count got %0d want 40", ret_count); end
      nCmp++; if (drop_err !== 1'b0) begin nBad++; $display("FAIL wrap_drop got %b want 0", drop_err); end
   endtask

   task automatic test_halt_drain();
      int pops = 0;
      do_reset();
      drive(2'b11, 64'h3000, 64'h3004, 32'h1, 32'h2, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      drive(2'b11, 64'h3008, 64'h300C, 32'h3, 32'h4, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      drive(2'b01, 64'h3010, 64'h0, 32'h5, 32'h0, 1'b0, 64'h0, 1'b1);
      #1;
      nCmp++; if (ret_ready !== 1'b1) begin nBad++; $display("FAIL halt_accept got %b want 1", ret_ready); end
      @(negedge clk);
      idle();
      #1;
      nCmp++; if (ret_ready !== 1'b0) begin nBad++; $display("FAIL halt_ready got %b want 0", ret_ready); end
      nCmp++; if (sim_halt !== 1'b0) begin nBad++; $display("FAIL halt_early got %b want 0", sim_halt); end
      trace_ready = 1'b1;
      #1;
      for (int cyc = 0; cyc < 20 && !sim_halt; cyc++) begin
         if (trace_valid) begin
            nCmp++; if (trace_pc !== 64'h3000 + 64'(4*pops)) begin nBad++; $display("FAIL halt_pc n=%0d got %h want %h", pops, trace_pc, 64'h3000 + 64'(4*pops)); end
            $display("halt: pop pc=%h", trace_pc);
            pops++;
         end
         @(negedge clk);
         #1;
      end
      nCmp++; if (pops != 5) begin nBad++; $display("FAIL halt_pops got %0d want 5", pops); end
      nCmp++; if (sim_halt !== 1'b1) begin nBad++; $display("FAIL halt_set got %b want 1", sim_halt); end
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL halt_valid got %b want 0", trace_valid); end
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, 64'h5000, 64'h5004, 32'h9, 32'h9, 1'b1, 64'h7, 1'b1);
         @(negedge clk);
      end
      idle();
      #1;
      nCmp++; if (sim_halt !== 1'b1) begin nBad++; $display("FAIL halt_sticky got %b want 1", sim_halt); end
      nCmp++; if (drop_err !== 1'b0) begin nBad++; $display("FAIL halt_drop got %b want 0", drop_err); end
      nCmp++; if (ret_count !== 64'd5) begin nBad++; $display("FAIL halt_count got %0d want 5", ret_count); end
      nCmp++; if (ret_ready !== 1'b0) begin nBad++; $display("FAIL halt_ready_late got %b want 0", ret_ready); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      drive(2'b11, 64'h4000, 64'h4004, 32'h1, 32'h2, 1'b0, 64'h0, 1'b0);
      @(negedge clk);
      drive(2'b01, 64'h4008, 64'h0, 32'h3, 32'h0, 1'b0, 64'h0, 1'b1);
      @(negedge clk);
      idle();
      #1;
      nCmp++; if (trace_valid !== 1'b1) begin nBad++; $display("FAIL mid_valid got %b want 1", trace_valid); end
      nCmp++; if (ret_ready !== 1'b0) begin nBad++; $display("FAIL mid_ready got %b want 0", ret_ready); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      nCmp++; if (trace_valid !== 1'b0) begin nBad++; $display("FAIL mid_rst_valid got %b want 0", trace_valid); end
      nCmp++; if (sim_halt !== 1'b0) begin nBad++; $display("FAIL mid_rst_halt got %b want 0", sim_halt); end
      nCmp++; if (ret_ready !== 1'b1) begin nBad++; $display("FAIL mid_rst_ready got %b want 1", ret_ready); end
      nCmp++; if (ret_count !== 64'h0) begin nBad++; $display("FAIL mid_rst_count got %0d want 0", ret_count); end
      $display("mid-drain reset: valid=%b halt=%b ready=%b count=%0d", trace_valid, sim_halt, ret_ready, ret_count);
   endtask

   initial begin
      rst = 1'b1;
      trace_ready = 1'b0;
      idle();
      test_reset();
      test_single();
      test_sparse_trap();
      test_backpressure();
      test_wrap();
      test_halt_drain();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
